// File: rtl/des_key_schedule_seq.sv
// Sequential DES subkey generator: PC-1 on start, one C/D rotation per accepted
// subkey, PC-2 of the registered halves presented as the current round key.
module des_key_schedule_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Tables hold FIPS 1-based bit numbers, MSB-first on both sides.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            idx       = 6'(64 - PC1[i]);
            r[55 - i] = k[idx];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            idx       = 6'(56 - PC2[i]);
            r[47 - i] = cd[idx];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // Encrypt shift for index r; decrypt uses the same amounts for r>=1, which
    // is the encrypt schedule walked backwards.
    function automatic logic [1:0] shiftFor(input logic [3:0] r);
        if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15)
            return 2'd1;
        return 2'd2;
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_decrypt;

    logic [55:0] w_pc1;
    logic [3:0]  w_nextRound;
    logic [1:0]  w_shift;
    logic        w_handshake;

    assign w_pc1       = pc1(key_in);
    assign w_nextRound = round + 4'd1;
    assign w_shift     = shiftFor(w_nextRound);
    assign w_handshake = subkey_valid && subkey_ready;
    assign subkey      = pc2({r_c, r_d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_c          <= '0;
            r_d          <= '0;
            r_decrypt    <= 1'b0;
            round        <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Decrypt starts at K16, which equals the unrotated PC-1 halves.
                        r_c          <= decrypt ? w_pc1[55:28] : rotl(w_pc1[55:28], 2'd1);
                        r_d          <= decrypt ? w_pc1[27:0]  : rotl(w_pc1[27:0],  2'd1);
                        r_decrypt    <= decrypt;
                        round        <= '0;
                        busy         <= 1'b1;
                        subkey_valid <= 1'b1;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_handshake) begin
                        if (round == 4'd15) begin
                            round        <= '0;
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            round <= w_nextRound;
                            r_c   <= r_decrypt ? rotr(r_c, w_shift) : rotl(r_c, w_shift);
                            r_d   <= r_decrypt ? rotr(r_d, w_shift) : rotl(r_d, w_shift);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Directed bench for des_key_schedule_seq: a scoreboard of model subkeys is
// filled at each start and drained by a monitor at every handshake.
module tb_des_key_schedule_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    des_key_schedule_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;
    localparam logic [63:0] PARITY_FLIP = 64'h0101010101010101;

    localparam int PC1T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    localparam int ENC_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int          checks;
    int          failures;
    int          handshakes;
    logic [47:0] expQ[$];
    logic [3:0]  roundQ[$];
    logic [47:0] lastRun [16];
    logic        stalled;
    logic [47:0] heldSub;
    logic [3:0]  heldRound;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] modelPc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            idx       = 6'(64 - PC1T[i]);
            r[55 - i] = k[idx];
        end
        return r;
    endfunction

    function automatic logic [47:0] modelPc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            idx       = 6'(56 - PC2T[i]);
            r[47 - i] = cd[idx];
        end
        return r;
    endfunction

    function automatic logic [27:0] modelRotl(input logic [27:0] x, input int n);
        logic [27:0] y;
        if (n == 0) return x;
        y = (x << n) | (x >> (28 - n));
        return y;
    endfunction

    // Model: each Ki from PC-1 halves rotated by the cumulative left shift;
    // decrypt order is the encrypt list reversed.
    task automatic pushExpected(input logic [63:0] key, input logic dec);
        logic [55:0] cd0;
        logic [47:0] ks [16];
        int          total;
        cd0   = modelPc1(key);
        total = 0;
        for (int r = 0; r < 16; r++) begin
            total += ENC_SHIFTS[r];
            ks[r] = modelPc2({modelRotl(cd0[55:28], total % 28), modelRotl(cd0[27:0], total % 28)});
        end
        for (int r = 0; r < 16; r++) begin
            expQ.push_back(dec ? ks[15 - r] : ks[r]);
            roundQ.push_back(4'(r));
        end
    endtask

    // Monitor: checks every handshake against the scoreboard and that stalled
    // outputs are held.
    always @(negedge clk) begin
        logic [47:0] e;
        logic [3:0]  er;
        if (!rst_n) begin
            stalled <= 1'b0;
        end else begin
            if (stalled && subkey_valid) begin
                checkOutput("stall_hold_subkey", subkey, heldSub);
                checkOutput("stall_hold_round", round, heldRound);
            end
            if (subkey_valid && subkey_ready) begin
                handshakes     <= handshakes + 1;
                lastRun[round] <= subkey;
                checkOutput("scoreboard_nonempty", expQ.size(), (expQ.size() == 0) ? 1 : expQ.size());
                if (expQ.size() != 0) begin
                    e  = expQ.pop_front();
                    er = roundQ.pop_front();
                    checkOutput("handshake_subkey", subkey, e);
                    checkOutput("handshake_round", round, er);
                end
            end
            stalled   <= subkey_valid && !subkey_ready;
            heldSub   <= subkey;
            heldRound <= round;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] key, input logic dec);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        pushExpected(key, dec);
        tick();
        start   = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input bit stall, output int cyclesTaken);
        int stallLeft;
        stallLeft   = 0;
        cyclesTaken = 0;
        while (cyclesTaken < maxCycles) begin
            if (stall) begin
                if (stallLeft > 0) begin
                    subkey_ready = 1'b0;
                    stallLeft--;
                end else begin
                    subkey_ready = 1'b1;
                    stallLeft    = $urandom_range(0, 5);
                end
                decrypt = 1'($urandom_range(0, 1));
            end
            tick();
            cyclesTaken++;
            if (done) break;
        end
        subkey_ready = 1'b1;
        checkOutput("done_seen", done, 1);
    endtask

    task automatic runToRound(input logic [3:0] target);
        int n;
        n = 0;
        while (round != target && n < 100) begin
            tick();
            n++;
        end
        checkOutput("reach_round", round, target);
    endtask

    initial begin
        int n;
        int hs0;
        checks       = 0;
        failures     = 0;
        handshakes   = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b1;
        tick();
        tick();
        checkOutput("reset_valid", subkey_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_round", round, 0);
        checkOutput("reset_subkey", subkey, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] encrypt vector");
        hs0 = handshakes;
        applyStimulus(KEY_A, 1'b0);
        checkOutput("first_valid", subkey_valid, 1);
        waitDone(40, 1'b0, n);
        checkOutput("enc_latency", 1 + n, 17);
        checkOutput("enc_handshakes", handshakes - hs0, 16);
        checkOutput("enc_k1", lastRun[0], 48'h1B02EFFC7072);
        checkOutput("enc_k2", lastRun[1], 48'h79AED9DBC9E5);
        checkOutput("enc_k16", lastRun[15], 48'hCB3D8B0E17F5);
        checkOutput("enc_queue_empty", expQ.size(), 0);
        checkOutput("enc_busy_low", busy, 0);
        tick();
        checkOutput("done_single_pulse", done, 0);

        $display("[TB] decrypt vector");
        hs0 = handshakes;
        applyStimulus(KEY_A, 1'b1);
        waitDone(40, 1'b0, n);
        checkOutput("dec_latency", 1 + n, 17);
        checkOutput("dec_handshakes", handshakes - hs0, 16);
        checkOutput("dec_r0", lastRun[0], 48'hCB3D8B0E17F5);
        checkOutput("dec_r14", lastRun[14], 48'h79AED9DBC9E5);
        checkOutput("dec_r15", lastRun[15], 48'h1B02EFFC7072);
        checkOutput("dec_queue_empty", expQ.size(), 0);
        tick();

        $display("[TB] back-pressure with decrypt toggling");
        hs0 = handshakes;
        applyStimulus(KEY_A, 1'b0);
        waitDone(300, 1'b1, n);
        checkOutput("bp_handshakes", handshakes - hs0, 16);
        checkOutput("bp_k1", lastRun[0], 48'h1B02EFFC7072);
        checkOutput("bp_k16", lastRun[15], 48'hCB3D8B0E17F5);
        checkOutput("bp_queue_empty", expQ.size(), 0);
        decrypt = 1'b0;
        tick();

        $display("[TB] start while busy");
        hs0 = handshakes;
        applyStimulus(KEY_A, 1'b0);
        runToRound(4'd5);
        key_in  = 64'hFFFFFFFFFFFFFFFF;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("busy_start_round", round, 6);
        waitDone(40, 1'b0, n);
        checkOutput("busy_handshakes", handshakes - hs0, 16);
        checkOutput("busy_k16", lastRun[15], 48'hCB3D8B0E17F5);
        checkOutput("busy_queue_empty", expQ.size(), 0);
        tick();

        $display("[TB] mid-run reset");
        applyStimulus(KEY_A, 1'b0);
        runToRound(4'd8);
        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_valid", subkey_valid, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_done", done, 0);
        checkOutput("async_rst_round", round, 0);
        checkOutput("async_rst_subkey", subkey, 0);
        expQ.delete();
        roundQ.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst_idle_valid", subkey_valid, 0);
            checkOutput("post_rst_idle_busy", busy, 0);
            checkOutput("post_rst_no_done", done, 0);
        end
        hs0 = handshakes;
        applyStimulus(KEY_A, 1'b1);
        waitDone(40, 1'b0, n);
        checkOutput("post_rst_handshakes", handshakes - hs0, 16);
        checkOutput("post_rst_r0", lastRun[0], 48'hCB3D8B0E17F5);
        tick();

        $display("[TB] parity bits and back-to-back start");
        hs0 = handshakes;
        applyStimulus(KEY_B, 1'b0);
        waitDone(40, 1'b0, n);
        applyStimulus(KEY_B ^ PARITY_FLIP, 1'b0);
        checkOutput("b2b_no_gap_valid", subkey_valid, 1);
        checkOutput("b2b_no_gap_round", round, 0);
        waitDone(40, 1'b0, n);
        checkOutput("b2b_latency", 1 + n, 17);
        checkOutput("b2b_handshakes", handshakes - hs0, 32);
        checkOutput("b2b_queue_empty", expQ.size(), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
- Sequential DES subkey generator. It converts a 64-bit key into the sixteen 48-bit round subkeys, one per handshake.
- Supports encryption order (K1..K16) and decryption order (K16..K1). For decryption it uses right rotations, so it never has to store the whole schedule.
- Sits beside the round pipeline. Each subkey is XORed with the expanded right half before the 48-to-32 S-box substitution layer.
- Subkey bit packing is MSB-first: bits [47:42] feed S-box 1 and bits [5:0] feed S-box 8.

Parameters:
- None. The DES tables are fixed constants from FIPS 46-3 (PC-1, PC-2, shift schedule).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new schedule; accepted only when busy=0
- decrypt  input  1  0 = encrypt order, 1 = decrypt order; sampled with start
- key_in  input  64  DES key; bit 63 = FIPS bit 1; parity bits ignored; sampled with start
- subkey  output  48  current round subkey, PC-2 of registered C,D; bit 47 = FIPS bit 1
- subkey_valid  output  1  subkey and round are valid
- subkey_ready  input  1  consumer accepts the subkey when subkey_valid=1 and subkey_ready=1
- round  output  4  index of the subkey currently presented, 0..15 (FIPS round number minus 1)
- busy  output  1  schedule in progress
- done  output  1  one-cycle pulse in the cycle after the 16th subkey is accepted

Behaviour:
- The design has one clock and one reset; the reset is asynchronous and active-low.
- Reset values: C=0, D=0, round=0, subkey_valid=0, busy=0, done=0, state=IDLE. subkey then reads PC2(0)=0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - start=1 in cycle T is accepted. It loads {C,D}=PC1(key_in), then applies the first rotation: encrypt rotates C and D left 1; decrypt applies none.
  - Latches the decrypt mode, sets round=0, busy=1, subkey_valid=1, and enters RUN.
  - The first subkey is valid in cycle T+1. Latency is 1 cycle.
- RUN:
  - subkey is combinational PC2({C,D}) from the registers and is stable while subkey_valid=1 and subkey_ready=0 (back-pressure holds everything).
  - On a handshake with round<15: round increments and C,D rotate by the amount for the next index r=round+1.
    - Encrypt: rotate left by ENC[r], with ENC = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - Decrypt: rotate right by DEC[r], with DEC = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On a handshake with round=15: subkey_valid=0, busy=0, done=1 for the next cycle, round returns to 0, state returns to IDLE.
  - Back-to-back operation: a start in the cycle where done=1 is accepted, since busy is already 0. Throughput is 17 cycles per key with subkey_ready held at 1.
- Rotations apply separately to the 28-bit C and D halves and wrap bit 27 to bit 0 (left) or bit 0 to bit 27 (right).
- start while busy=1 is ignored. key_in and decrypt are not re-sampled and the current schedule continues undisturbed.
- decrypt changing during RUN has no effect; only the value latched at start is used.
- Reset asserted mid-schedule:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - No done pulse is issued.
  - After rst_n deasserts, a new start is required.
- Parity bits (FIPS bits 8,16,...,64) never affect the output, since PC-1 drops them.
- The 28-bit rotation totals are invariant checks:
  - Encrypt: after the round-15 rotation, C,D equal PC1(key) rotated left 28, i.e. unchanged.
  - Decrypt: the right-rotation sum over rounds 1..15 equals 27.

Test Plan:
- Encrypt vector: key_in=0x133457799BBCDFF1, decrypt=0, subkey_ready=1 → round0 subkey=0x1B02EFFC7072, round1=0x79AED9DBC9E5, round15=0xCB3D8B0E17F5; done pulses once, 17 cycles after start.
- Decrypt vector: same key, decrypt=1 → round0=0xCB3D8B0E17F5, round14=0x79AED9DBC9E5, round15=0x1B02EFFC7072. Full sequence equals the encrypt sequence reversed, checked against a software model.
- Back-pressure: drop subkey_ready randomly for 0–5 cycles → subkey and round are held constant while stalled, exactly 16 handshakes occur, and the values are unchanged versus the no-stall run.
- Start while busy: pulse start with key 0xFFFFFFFFFFFFFFFF at round 5 → ignored, and the original 0x1334... schedule completes correctly.
- Mid-run reset: assert rst_n=0 at round 8 → subkey_valid, busy, done and round go to 0 asynchronously. After release with no start, outputs stay idle; a new start runs cleanly.
- Parity and back-to-back: key 0x123456789ABCDEF0, then the same key with all parity LSBs flipped (XOR 0x0101010101010101), issued in the done cycle → identical 16-subkey sequences with no idle gap.
